// File: rtl/bit_deserializer.sv
// Serial-to-parallel collector: LSB-first valid/ready bit stream into WIDTH-bit words.
// Optional early word completion on io_flush when BIT_DESER_FLUSH_EN is defined.
module bit_deserializer #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   input  logic             io_in_bits,
   output logic             io_in_ready,
   output logic             io_out_valid,
   output logic [WIDTH-1:0] io_out_bits,
   input  logic             io_out_ready,
   output logic [5:0]       io_bit_count,
   output logic [15:0]      io_word_count
`ifdef BIT_DESER_FLUSH_EN
   ,
   input  logic             io_flush
`endif
);

   // state      | meaning
   // ST_COLLECT | accepting bits into the collect register
   // ST_HOLD    | full word parked in collect register, waiting for the slot
   typedef enum logic {ST_COLLECT, ST_HOLD} state_e;

   localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);
   localparam logic [5:0] CNT_FULL = 6'(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   collect_q, collect_d;
   logic [5:0]         cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_bits_q, out_bits_d;
   logic [15:0]        word_cnt_q, word_cnt_d;

   logic               in_hs, out_hs, slot_free, complete, load;
   logic [WIDTH-1:0]   shift_word, load_word;

   assign io_in_ready   = (state_q == ST_COLLECT);
   assign io_out_valid  = out_valid_q;
   assign io_out_bits   = out_bits_q;
   assign io_bit_count  = cnt_q;
   assign io_word_count = word_cnt_q;

   assign in_hs     = io_in_valid & (state_q == ST_COLLECT);
   assign out_hs    = out_valid_q & io_out_ready;
   assign slot_free = ~out_valid_q | io_out_ready;

   always_comb begin
      shift_word = collect_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (in_hs && (cnt_q == 6'(i))) shift_word[i] = io_in_bits;
      end
   end

   always_comb begin
      state_d     = state_q;
      collect_d   = collect_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_bits_d  = out_bits_q;
      word_cnt_d  = word_cnt_q + {15'd0, out_hs};
      complete    = 1'b0;
      load        = 1'b0;
      load_word   = '0;

      case (state_q)
         ST_COLLECT: begin
            complete = in_hs && (cnt_q == CNT_LAST);
`ifdef BIT_DESER_FLUSH_EN
            if (io_flush && (in_hs || (cnt_q != 6'd0))) complete = 1'b1;
`endif
            if (complete) begin
               collect_d = '0;
               cnt_d     = '0;
               if (slot_free) begin
                  load      = 1'b1;
                  load_word = shift_word;
               end else begin
                  // Park the word; count shows a full word until it moves out.
                  collect_d = shift_word;
                  cnt_d     = CNT_FULL;
                  state_d   = ST_HOLD;
               end
            end else if (in_hs) begin
               collect_d = shift_word;
               cnt_d     = cnt_q + 6'd1;
            end
         end
         ST_HOLD: begin
            if (slot_free) begin
               load      = 1'b1;
               load_word = collect_q;
               collect_d = '0;
               cnt_d     = '0;
               state_d   = ST_COLLECT;
            end
         end
         default: state_d = ST_COLLECT;
      endcase

      if (load) begin
         out_valid_d = 1'b1;
         out_bits_d  = load_word;
      end else if (out_hs) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_COLLECT;
         collect_q   <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_bits_q  <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         collect_q   <= collect_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_bits_q  <= out_bits_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer (WIDTH=32); flush case runs when BIT_DESER_FLUSH_EN is defined.
module tb_bit_deserializer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        io_in_valid = 1'b0;
   logic        io_in_bits = 1'b0;
   logic        io_in_ready;
   logic        io_out_valid;
   logic [31:0] io_out_bits;
   logic        io_out_ready = 1'b0;
   logic [5:0]  io_bit_count;
   logic [15:0] io_word_count;
   logic        io_flush = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   bit_deserializer #(.WIDTH(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .io_in_valid   (io_in_valid),
      .io_in_bits    (io_in_bits),
      .io_in_ready   (io_in_ready),
      .io_out_valid  (io_out_valid),
      .io_out_bits   (io_out_bits),
      .io_out_ready  (io_out_ready),
      .io_bit_count  (io_bit_count),
      .io_word_count (io_word_count)
`ifdef BIT_DESER_FLUSH_EN
      ,
      .io_flush      (io_flush)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drives 32 bits LSB first; returns at the falling edge after the last bit was taken.
   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         check("in_ready_stream", {31'd0, io_in_ready}, 32'd1);
         io_in_valid = 1'b1;
         io_in_bits  = w[i];
      end
      @(negedge clock);
      io_in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   logic [31:0] words [3];

   initial begin
      #2;
      check("rst_in_ready",   {31'd0, io_in_ready},  32'd1);
      check("rst_out_valid",  {31'd0, io_out_valid}, 32'd0);
      check("rst_out_bits",   io_out_bits,           32'd0);
      check("rst_bit_count",  {26'd0, io_bit_count}, 32'd0);
      check("rst_word_count", {16'd0, io_word_count}, 32'd0);

      // First word after reset release
      @(negedge clock);
      reset = 1'b0;
      io_out_ready = 1'b1;
      send_word(32'h0000_0017);
      check("w1_valid", {31'd0, io_out_valid}, 32'd1);
      check("w1_bits",  io_out_bits, 32'h0000_0017);
      check("w1_bitcnt", {26'd0, io_bit_count}, 32'd0);
      @(negedge clock);
      check("w1_valid_drop", {31'd0, io_out_valid}, 32'd0);
      check("w1_wordcnt", {16'd0, io_word_count}, 32'd1);

      // Continuous stream of three words
      do_reset();
      words[0] = 32'hFFFF_FFFF;
      words[1] = 32'hA5A5_A5A5;
      words[2] = 32'h0000_0001;
      for (int k = 0; k <= 96; k++) begin
         @(negedge clock);
         if (k > 0) begin
            check("cont_valid", {31'd0, io_out_valid}, {31'd0, (k % 32) == 0});
            if ((k % 32) == 0) check("cont_bits", io_out_bits, words[k/32 - 1]);
            check("cont_in_ready", {31'd0, io_in_ready}, 32'd1);
         end
         if (k < 96) begin
            io_in_valid = 1'b1;
            io_in_bits  = words[k/32][k % 32];
         end else begin
            io_in_valid = 1'b0;
         end
      end
      @(negedge clock);
      check("cont_wordcnt", {16'd0, io_word_count}, 32'd3);

      // Back-pressure into HOLD
      do_reset();
      io_out_ready = 1'b0;
      send_word(32'h1234_5678);
      check("bp_a_valid", {31'd0, io_out_valid}, 32'd1);
      check("bp_a_bits", io_out_bits, 32'h1234_5678);
      send_word(32'h9ABC_DEF0);
      check("bp_hold_ready", {31'd0, io_in_ready}, 32'd0);
      check("bp_hold_bitcnt", {26'd0, io_bit_count}, 32'd32);
      check("bp_hold_a", io_out_bits, 32'h1234_5678);
      check("bp_hold_valid", {31'd0, io_out_valid}, 32'd1);
      @(negedge clock);
      check("bp_hold_a2", io_out_bits, 32'h1234_5678);
      check("bp_hold_ready2", {31'd0, io_in_ready}, 32'd0);
      io_out_ready = 1'b1;
      @(negedge clock);
      check("bp_b_bits", io_out_bits, 32'h9ABC_DEF0);
      check("bp_b_valid", {31'd0, io_out_valid}, 32'd1);
      check("bp_exit_ready", {31'd0, io_in_ready}, 32'd1);
      check("bp_exit_bitcnt", {26'd0, io_bit_count}, 32'd0);
      check("bp_wordcnt1", {16'd0, io_word_count}, 32'd1);
      @(negedge clock);
      check("bp_wordcnt2", {16'd0, io_word_count}, 32'd2);
      check("bp_b_drop", {31'd0, io_out_valid}, 32'd0);

      // Reset mid-word with a word parked in the slot
      do_reset();
      io_out_ready = 1'b0;
      send_word(32'h0000_0017);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         io_in_valid = 1'b1;
         io_in_bits  = 1'b1;
      end
      @(negedge clock);
      io_in_valid = 1'b0;
      check("mid_bitcnt", {26'd0, io_bit_count}, 32'd10);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, io_out_valid}, 32'd0);
      check("mid_rst_bits", io_out_bits, 32'd0);
      check("mid_rst_bitcnt", {26'd0, io_bit_count}, 32'd0);
      check("mid_rst_ready", {31'd0, io_in_ready}, 32'd1);
      check("mid_rst_wordcnt", {16'd0, io_word_count}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      io_out_ready = 1'b1;
      send_word(32'h0000_0001);
      check("mid_clean_bits", io_out_bits, 32'h0000_0001);
      check("mid_clean_valid", {31'd0, io_out_valid}, 32'd1);

      // Word counter wrap, with 65534 deliveries preloaded
      @(negedge clock);
      force dut.word_cnt_q = 16'hFFFE;
      #1;
      release dut.word_cnt_q;
      send_word(32'hCAFE_0001);
      @(negedge clock);
      check("wrap_ffff", {16'd0, io_word_count}, 32'h0000_FFFF);
      send_word(32'hCAFE_0002);
      @(negedge clock);
      check("wrap_zero", {16'd0, io_word_count}, 32'h0000_0000);

`ifdef BIT_DESER_FLUSH_EN
      // Flush alongside the third bit: 1,0,1 -> 0x5
      do_reset();
      io_out_ready = 1'b1;
      @(negedge clock);
      io_in_valid = 1'b1; io_in_bits = 1'b1;
      @(negedge clock);
      io_in_bits = 1'b0;
      @(negedge clock);
      io_in_bits = 1'b1; io_flush = 1'b1;
      @(negedge clock);
      io_in_valid = 1'b0; io_flush = 1'b0;
      check("flush_bits", io_out_bits, 32'h0000_0005);
      check("flush_valid", {31'd0, io_out_valid}, 32'd1);
      check("flush_bitcnt", {26'd0, io_bit_count}, 32'd0);
      io_flush = 1'b1;
      @(negedge clock);
      io_flush = 1'b0;
      check("flush_empty_ignored", {31'd0, io_out_valid}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
